// File: rtl/rtc_bus_pkg.sv
// rtl/rtc_bus_pkg.sv - step codes and step-walk helper for the RTC bus sequencer
package rtc_bus_pkg;

  localparam logic [4:0] ST_IDLE   = 5'd0;
  localparam logic [4:0] ST_SETUP1 = 5'd1;
  localparam logic [4:0] ST_SETUP2 = 5'd2;
  localparam logic [4:0] ST_SETUP3 = 5'd3;
  localparam logic [4:0] ST_ALE    = 5'd4;
  localparam logic [4:0] ST_RHIZ   = 5'd5;
  localparam logic [4:0] ST_RSET   = 5'd6;
  localparam logic [4:0] ST_RDLO   = 5'd7;
  localparam logic [4:0] ST_RDHI   = 5'd8;
  localparam logic [4:0] ST_RHOLD1 = 5'd9;
  localparam logic [4:0] ST_RHOLD2 = 5'd10;
  localparam logic [4:0] ST_PHASE  = 5'd11;
  localparam logic [4:0] ST_WRLO   = 5'd12;
  localparam logic [4:0] ST_WRHI   = 5'd13;
  localparam logic [4:0] ST_ADHI   = 5'd14;
  localparam logic [4:0] ST_WTAIL1 = 5'd15;
  localparam logic [4:0] ST_WTAIL2 = 5'd16;
  localparam logic [4:0] ST_END    = 5'd17;

  localparam int N_STEPS = 15;

  typedef struct packed {
    logic [4:0] code;
    logic       phase;
  } step_t;

  // Successor of a non-idle code; code 14 forks on direction and on which pass it is.
  function automatic step_t next_step(input logic [4:0] code, input logic wr, input logic phase);
    step_t s;
    s.code  = ST_IDLE;
    s.phase = phase;
    case (code)
      ST_SETUP1: s.code = ST_SETUP2;
      ST_SETUP2: s.code = ST_SETUP3;
      ST_SETUP3: s.code = ST_ALE;
      ST_ALE:    s.code = ST_PHASE;
      ST_PHASE:  s.code = ST_WRLO;
      ST_WRLO:   s.code = ST_WRHI;
      ST_WRHI:   s.code = ST_ADHI;
      ST_ADHI: begin
        if (!wr) begin
          s.code  = ST_RHIZ;
          s.phase = 1'b0;
        end else if (!phase) begin
          s.code  = ST_PHASE;
          s.phase = 1'b1;
        end else begin
          s.code  = ST_WTAIL1;
          s.phase = 1'b0;
        end
      end
      ST_RHIZ:   s.code = ST_RSET;
      ST_RSET:   s.code = ST_RDLO;
      ST_RDLO:   s.code = ST_RDHI;
      ST_RDHI:   s.code = ST_RHOLD1;
      ST_RHOLD1: s.code = ST_RHOLD2;
      ST_RHOLD2: s.code = ST_END;
      ST_WTAIL1: s.code = ST_WTAIL2;
      ST_WTAIL2: s.code = ST_END;
      default: begin
        s.code  = ST_IDLE;
        s.phase = 1'b0;
      end
    endcase
    return s;
  endfunction

endpackage

// File: rtl/rtc_bus_sequencer_timer.sv
// rtl/rtc_bus_sequencer_timer.sv - modulo-STEP_CYC step timer with load
module rtc_step_timer #(
  parameter int STEP_CYC = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic load,
  input  logic en,
  output logic step_wrap
);

  localparam int CW = (STEP_CYC > 2) ? $clog2(STEP_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign step_wrap = en && !load && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = step_wrap ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rtc_bus_sequencer.sv
// rtl/rtc_bus_sequencer.sv - RTC multiplexed AD bus-cycle sequencer
module rtc_bus_sequencer
  import rtc_bus_pkg::*;
#(
  parameter int STEP_CYC = 4,
  parameter int DW       = 8
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          req,
  input  logic          wr_nrd,
  input  logic [DW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] rdata,
  output logic [4:0]    estado,
  output logic          cont_es,
  output logic [DW-1:0] ad_out,
  output logic          ad_oe,
  input  logic [DW-1:0] ad_in
);

  logic [4:0]    estado_q, estado_d;
  logic          phase_q, phase_d;
  logic          done_q, done_d;
  logic          guard_q, guard_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [DW-1:0] ad_out_q, ad_out_d;
  logic          ad_oe_q, ad_oe_d;
  logic          wr_q;
  logic [DW-1:0] addr_q, wdata_q;

  logic  idle, accept, tmr_en, step_wrap;
  step_t nxt;

  assign idle   = (estado_q == ST_IDLE);
  assign accept = idle && req && guard_q;
  // The timer also paces the CS recovery window while idle.
  assign tmr_en = !idle || !guard_q;

  rtc_step_timer #(.STEP_CYC(STEP_CYC)) u_timer (
    .clk       (clk),
    .clr       (clr),
    .load      (accept),
    .en        (tmr_en),
    .step_wrap (step_wrap)
  );

  always_comb begin
    nxt      = next_step(estado_q, wr_q, phase_q);
    estado_d = estado_q;
    phase_d  = phase_q;
    done_d   = 1'b0;
    guard_d  = guard_q;
    rdata_d  = rdata_q;
    ad_out_d = ad_out_q;
    ad_oe_d  = ad_oe_q;
    if (accept) begin
      estado_d = ST_SETUP1;
      phase_d  = 1'b0;
    end else if (step_wrap && !idle) begin
      estado_d = nxt.code;
      phase_d  = nxt.phase;
      if (estado_q == ST_END) begin
        done_d  = 1'b1;
        guard_d = 1'b0;
      end
      if (estado_q == ST_RDLO) begin
        rdata_d = ad_in;
      end
      if (nxt.code == ST_ALE) begin
        ad_oe_d  = 1'b1;
        ad_out_d = addr_q;
      end
      if (nxt.code == ST_PHASE && nxt.phase) begin
        ad_out_d = wdata_q;
      end
      if (nxt.code == ST_WTAIL1 || nxt.code == ST_RHIZ) begin
        ad_oe_d = 1'b0;
      end
    end else if (step_wrap && idle) begin
      guard_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      estado_q <= ST_IDLE;
      phase_q  <= 1'b0;
      done_q   <= 1'b0;
      guard_q  <= 1'b1;
      rdata_q  <= '0;
      ad_out_q <= '0;
      ad_oe_q  <= 1'b0;
    end else begin
      estado_q <= estado_d;
      phase_q  <= phase_d;
      done_q   <= done_d;
      guard_q  <= guard_d;
      rdata_q  <= rdata_d;
      ad_out_q <= ad_out_d;
      ad_oe_q  <= ad_oe_d;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      wr_q    <= wr_nrd;
      addr_q  <= addr;
      wdata_q <= wdata;
    end
  end

  assign busy    = !idle;
  assign done    = done_q;
  assign rdata   = rdata_q;
  assign estado  = estado_q;
  assign cont_es = phase_q;
  assign ad_out  = ad_out_q;
  assign ad_oe   = ad_oe_q;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// tb/tb_rtc_bus_sequencer.sv - directed self-checking bench for rtc_bus_sequencer
module tb_rtc_bus_sequencer;

  localparam logic [4:0] WR_SEQ [15] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd11, 5'd12, 5'd13, 5'd14,
                                         5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd17};
  localparam logic [4:0] RD_SEQ [15] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd11, 5'd12, 5'd13, 5'd14,
                                         5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd17};

  logic       clk = 1'b0;
  logic       clr_r    [2];
  logic       req_r    [2];
  logic       wr_r     [2];
  logic [7:0] addr_r   [2];
  logic [7:0] wdata_r  [2];
  logic [7:0] ad_in_r  [2];
  logic       busy_w   [2];
  logic       done_w   [2];
  logic [7:0] rdata_w  [2];
  logic [4:0] estado_w [2];
  logic       cont_w   [2];
  logic [7:0] ad_out_w [2];
  logic       ad_oe_w  [2];
  logic [7:0] model_rd [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rtc_bus_sequencer #(.STEP_CYC(4), .DW(8)) dut4 (
    .clk(clk), .clr(clr_r[0]), .req(req_r[0]), .wr_nrd(wr_r[0]), .addr(addr_r[0]),
    .wdata(wdata_r[0]), .busy(busy_w[0]), .done(done_w[0]), .rdata(rdata_w[0]),
    .estado(estado_w[0]), .cont_es(cont_w[0]), .ad_out(ad_out_w[0]), .ad_oe(ad_oe_w[0]),
    .ad_in(ad_in_r[0])
  );

  rtc_bus_sequencer #(.STEP_CYC(2), .DW(8)) dut2 (
    .clk(clk), .clr(clr_r[1]), .req(req_r[1]), .wr_nrd(wr_r[1]), .addr(addr_r[1]),
    .wdata(wdata_r[1]), .busy(busy_w[1]), .done(done_w[1]), .rdata(rdata_w[1]),
    .estado(estado_w[1]), .cont_es(cont_w[1]), .ad_out(ad_out_w[1]), .ad_oe(ad_oe_w[1]),
    .ad_in(ad_in_r[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input int d);
    check("rst_estado", estado_w[d], 0);
    check("rst_cont_es", cont_w[d], 0);
    check("rst_busy", busy_w[d], 0);
    check("rst_done", done_w[d], 0);
    check("rst_rdata", rdata_w[d], 0);
    check("rst_ad_out", ad_out_w[d], 0);
    check("rst_ad_oe", ad_oe_w[d], 0);
  endtask

  task automatic start(input int d, input logic wr, input logic [7:0] a, input logic [7:0] wd);
    req_r[d]   = 1'b1;
    wr_r[d]    = wr;
    addr_r[d]  = a;
    wdata_r[d] = wd;
    tick();
    req_r[d] = 1'b0;
  endtask

  // Walks the 15 steps from cycle t+1 and ends in the done cycle.
  task automatic body(input int d, input int s, input logic wr, input logic [7:0] a,
                      input logic [7:0] wd, input logic [7:0] rv, input logic late,
                      input logic poke, input int abort_k, input logic hold);
    logic [4:0] code;
    logic       ph, oe;
    logic [7:0] ob;
    for (int k = 0; k < 15; k++) begin
      for (int c = 0; c < s; c++) begin
        code = wr ? WR_SEQ[k] : RD_SEQ[k];
        ph   = wr && (k >= 8) && (k <= 11);
        oe   = ((k >= 3) && (k <= 7)) || ph;
        ob   = (wr && k >= 8) ? wd : a;
        if (!wr && k == 11 && c == 0) model_rd[d] = rv;
        check("estado", estado_w[d], code);
        check("cont_es", cont_w[d], ph);
        check("ad_oe", ad_oe_w[d], oe);
        check("busy", busy_w[d], 1);
        check("done_low", done_w[d], 0);
        check("rdata", rdata_w[d], model_rd[d]);
        if (k >= 3) check("ad_out", ad_out_w[d], ob);
        if (k == abort_k && c == 1) begin
          clr_r[d] = 1'b1;
          #2;
          model_rd[d] = 8'h00;
          check_zero(d);
          return;
        end
        ad_in_r[d] = (k == 10 && (!late || c == s - 1)) ? rv : ~rv;
        if (poke && k == 2 && c == 0) begin
          req_r[d]   = 1'b1;
          wr_r[d]    = ~wr;
          addr_r[d]  = ~a;
          wdata_r[d] = ~wd;
        end
        if (poke && k == 5 && c == 0) req_r[d] = 1'b0;
        if (hold && k == 14 && c == 0) req_r[d] = 1'b1;
        tick();
      end
    end
    check("end_estado", estado_w[d], 0);
    check("end_done", done_w[d], 1);
    check("end_busy", busy_w[d], 0);
    check("end_cont_es", cont_w[d], 0);
    check("end_ad_oe", ad_oe_w[d], 0);
    check("end_rdata", rdata_w[d], model_rd[d]);
  endtask

  task automatic idle_gap(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check("gap_estado", estado_w[d], 0);
      check("gap_done", done_w[d], 0);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      clr_r[d] = 1'b1; req_r[d] = 1'b0; wr_r[d] = 1'b0;
      addr_r[d] = 8'h00; wdata_r[d] = 8'h00; ad_in_r[d] = 8'h00; model_rd[d] = 8'h00;
    end
    tick();
    tick();
    check_zero(0);
    check_zero(1);
    clr_r[0] = 1'b0;
    clr_r[1] = 1'b0;

    // write accepted on the first clock after release, with mid-transaction input noise
    start(0, 1'b1, 8'h0A, 8'h26);
    body(0, 4, 1'b1, 8'h0A, 8'h26, 8'h00, 1'b0, 1'b1, -1, 1'b0);
    wr_r[0] = 1'b1; addr_r[0] = 8'h0A; wdata_r[0] = 8'h26;
    idle_gap(0, 6);

    // write aborted by clr in code 12, then immediate read
    start(0, 1'b1, 8'h0A, 8'h26);
    body(0, 4, 1'b1, 8'h0A, 8'h26, 8'h00, 1'b0, 1'b0, 5, 1'b0);
    clr_r[0] = 1'b0;
    start(0, 1'b0, 8'h0C, 8'h00);
    body(0, 4, 1'b0, 8'h0C, 8'h00, 8'h5A, 1'b0, 1'b0, -1, 1'b0);
    idle_gap(0, 6);

    // req held across done: next estado=1 exactly STEP_CYC+1 clocks after done
    start(0, 1'b0, 8'h0C, 8'h00);
    body(0, 4, 1'b0, 8'h0C, 8'h00, 8'h77, 1'b0, 1'b0, -1, 1'b1);
    idle_gap(0, 4);
    tick();
    req_r[0] = 1'b0;
    body(0, 4, 1'b0, 8'h0C, 8'h00, 8'h99, 1'b0, 1'b0, -1, 1'b0);
    idle_gap(0, 2);

    // STEP_CYC=2 read, data only valid on the last clock of code 7
    start(1, 1'b0, 8'h0C, 8'h00);
    body(1, 2, 1'b0, 8'h0C, 8'h00, 8'h33, 1'b1, 1'b0, -1, 1'b0);
    idle_gap(1, 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
